// File: rtl/jk_reg_counter_if.sv
// jk_reg_counter_if: control and state bundle for jk_reg_counter.
//   en    update enable (0 = hold q, tc low)
//   mode  00 JK, 01 count up, 10 count down, 11 rotate left
//   j, k  per-bit JK inputs, used in mode 00 only
//   q     registered state
//   tc    registered terminal-count pulse
// master drives the controls; slave (the register) drives q and tc.
interface jk_reg_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (output en, mode, j, k, input q, tc);
  modport slave  (input en, mode, j, k, output q, tc);
endinterface

// File: rtl/jk_reg_counter.sv
// jk_reg_counter: WIDTH-bit register built from per-bit JK cells.
// Every mode (JK, up, down, rotate) is expressed as a {j,k} drive per cell,
// so all state lives in the cells; tc is a separate registered flag.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (q = RST_VAL, tc = 0)
//   bus    jk_reg_counter_if.slave (en, mode, j, k in; q, tc out)
// Optional build macro JK_REG_COUNTER_SAT_EN: counting saturates at
// all-ones (up) / zero (down) and holds tc high on each saturated cycle.

module jk_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_BIT;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_reg_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_reg_counter_if.slave  bus
);
  typedef enum logic [1:0] {
    MODE_JK  = 2'b00,
    MODE_UP  = 2'b01,
    MODE_DN  = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drv_t;

  jk_drv_t [WIDTH-1:0] drv;
  logic    [WIDTH-1:0] q;
  logic    [WIDTH-1:0] ones_below;   // bits 0..i-1 all 1 (up toggle term)
  logic    [WIDTH-1:0] zeros_below;  // bits 0..i-1 all 0 (down toggle term)
  logic    [WIDTH-1:0] rot;
  logic                all_ones, all_zero, tc_nxt;

  assign ones_below[0]  = 1'b1;
  assign zeros_below[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_prefix
    assign ones_below[i]  = &q[i-1:0];
    assign zeros_below[i] = ~|q[i-1:0];
  end

  assign all_ones = &q;
  assign all_zero = ~|q;
  assign rot      = {q[WIDTH-2:0], q[WIDTH-1]};

  always_comb begin
    drv    = '0;  // {0,0} = hold
    tc_nxt = 1'b0;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_JK: begin
          for (int i = 0; i < WIDTH; i++) drv[i] = '{j: bus.j[i], k: bus.k[i]};
        end
        MODE_UP: begin
          tc_nxt = all_ones;
`ifdef JK_REG_COUNTER_SAT_EN
          if (!all_ones)
`endif
          for (int i = 0; i < WIDTH; i++) drv[i] = '{j: ones_below[i], k: ones_below[i]};
        end
        MODE_DN: begin
          tc_nxt = all_zero;
`ifdef JK_REG_COUNTER_SAT_EN
          if (!all_zero)
`endif
          for (int i = 0; i < WIDTH; i++) drv[i] = '{j: zeros_below[i], k: zeros_below[i]};
        end
        default: begin
          // Rotate is a full load of the rotated value: j = d, k = ~d.
          for (int i = 0; i < WIDTH; i++) drv[i] = '{j: rot[i], k: ~rot[i]};
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(.RST_BIT(RST_VAL[i])) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (drv[i].j),
      .k     (drv[i].k),
      .q     (q[i])
    );
  end

  assign bus.q = q;

  logic tc_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc_r <= 1'b0;
    else        tc_r <= tc_nxt;
  end
  assign bus.tc = tc_r;
endmodule

// File: tb/tb_jk_reg_counter.sv
module tb_jk_reg_counter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [4:0] sb[$];     // expected {q, tc} per clock step
  logic [3:0] mq = 4'h0; // model state

  jk_reg_counter_if #(.WIDTH(4)) bus ();

  jk_reg_counter #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] predict(input logic e, input logic [1:0] m,
                                         input logic [3:0] jj, input logic [3:0] kk,
                                         input logic [3:0] cur);
    logic [3:0] nq;
    logic       ntc;
    nq  = cur;
    ntc = 1'b0;
    if (e) begin
      case (m)
        2'b00: nq = (jj & ~cur) | (~kk & cur);
        2'b01: begin
          ntc = (cur == 4'hF);
`ifdef JK_REG_COUNTER_SAT_EN
          nq = ntc ? cur : cur + 4'd1;
`else
          nq = cur + 4'd1;
`endif
        end
        2'b10: begin
          ntc = (cur == 4'h0);
`ifdef JK_REG_COUNTER_SAT_EN
          nq = ntc ? cur : cur - 4'd1;
`else
          nq = cur - 4'd1;
`endif
        end
        default: nq = {cur[2:0], cur[3]};
      endcase
    end
    return {nq, ntc};
  endfunction

  // Drive one cycle of stimulus, push the model's prediction, advance past the edge.
  task automatic step(input logic e, input logic [1:0] m, input logic [3:0] jj, input logic [3:0] kk);
    logic [4:0] p;
    bus.en = e; bus.mode = m; bus.j = jj; bus.k = kk;
    p = predict(e, m, jj, kk, mq);
    mq = p[4:1];
    sb.push_back(p);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    logic [4:0] got, exp;
    step(1'b1, 2'b00, v, ~v);
    got = {bus.q, bus.tc}; exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL load q=%h tc=%b expected q=%h tc=%b", got[4:1], got[0], exp[4:1], exp[0]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 2'b00; bus.j = '0; bus.k = '0;
    #2;
    n_cmp++;
    if (bus.q !== 4'h0 || bus.tc !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_initial q=%h tc=%b expected q=0 tc=0", bus.q, bus.tc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(4'hA);
    // Mid-cycle reset: q and tc clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.q !== 4'h0 || bus.tc !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async q=%h tc=%b expected q=0 tc=0", bus.q, bus.tc);
    end
    mq = 4'h0;
    bus.en = 1'b1; bus.mode = 2'b01;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.q !== 4'h0 || bus.tc !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold q=%h tc=%b expected q=0 tc=0", bus.q, bus.tc);
    end
    rst_n = 1'b1;
    step(1'b0, 2'b01, 4'h0, 4'h0);
    begin
      logic [4:0] got, exp;
      got = {bus.q, bus.tc}; exp = sb.pop_front(); n_cmp++;
      if (got !== exp || got !== 5'b0000_0) begin
        n_bad++;
        $display("FAIL reset_release q=%h tc=%b expected q=%h tc=%b", got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_jk;
    logic [3:0] js[3] = '{4'b1010, 4'b1111, 4'b0000};
    logic [3:0] ks[3] = '{4'b0100, 4'b1111, 4'b0000};
    logic [3:0] want[3] = '{4'b1010, 4'b0101, 4'b0101};
    logic [4:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00, js[i], ks[i]);
      got = {bus.q, bus.tc}; exp = sb.pop_front(); n_cmp++;
      if (got !== exp || got[4:1] !== want[i]) begin
        n_bad++;
        $display("FAIL jk[%0d] q=%h tc=%b expected q=%h tc=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_count(input string name, input logic [1:0] m, input logic [3:0] start, input int n);
    logic [4:0] got, exp;
    load(start);
    for (int i = 0; i < n; i++) begin
      step(1'b1, m, 4'($urandom), 4'($urandom));
      got = {bus.q, bus.tc}; exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s[%0d] q=%h tc=%b expected q=%h tc=%b", name, i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_en_hold;
    logic [4:0] got, exp;
    load(4'hF);
    step(1'b0, 2'b01, 4'h0, 4'h0);
    got = {bus.q, bus.tc}; exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL en_hold q=%h tc=%b expected q=%h tc=%b", got[4:1], got[0], exp[4:1], exp[0]);
    end
    step(1'b1, 2'b01, 4'h0, 4'h0);
    got = {bus.q, bus.tc}; exp = sb.pop_front(); n_cmp++;
    if (got !== exp || got[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL en_wrap q=%h tc=%b expected q=%h tc=%b", got[4:1], got[0], exp[4:1], exp[0]);
    end
    // Reset while tc is high: pulse must drop at once.
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.tc !== 1'b0 || bus.q !== 4'h0) begin
      n_bad++;
      $display("FAIL tc_reset q=%h tc=%b expected q=0 tc=0", bus.q, bus.tc);
    end
    mq = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [4:0] got, exp;
    // Up-to-down switch at all-ones: no tc, q = E.
    load(4'hF);
    step(1'b1, 2'b10, 4'h0, 4'h0);
    got = {bus.q, bus.tc}; exp = sb.pop_front(); n_cmp++;
    if (got !== exp || got !== 5'b1110_0) begin
      n_bad++;
      $display("FAIL switch_dir q=%h tc=%b expected q=%h tc=%b", got[4:1], got[0], exp[4:1], exp[0]);
    end
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom), 4'($urandom));
      got = {bus.q, bus.tc}; exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random[%0d] q=%h tc=%b expected q=%h tc=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jk();
    test_count("up", 2'b01, 4'hD, 4);
    test_count("down", 2'b10, 4'h1, 3);
    test_count("rotate", 2'b11, 4'b1001, 2);
    test_count("up_long", 2'b01, 4'h0, 20);
    test_en_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
